// File: rtl/hdmi_i2c_config.sv
// HDMI transmitter register loader: replays a fixed 12-entry table
// over a counter-timed I2C master after power-up or on request.
module hdmi_i2c_config #(
  parameter int          CLK_DIV        = 125,
  parameter logic [23:0] POWERUP_CYCLES = 24'd10_000_000,
  parameter logic [6:0]  DEV_ADDR       = 7'h39,
  parameter logic [15:0] GAP_CYCLES     = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] index
);

  typedef enum logic [2:0] {
    S_POWERUP, S_IDLE, S_START, S_BYTE,
    S_ACK, S_STOP, S_GAP, S_DONE
  } state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [23:0] PU_M1  = POWERUP_CYCLES - 24'd1;
  localparam logic [23:0] GAP_M1 = {8'd0, GAP_CYCLES} - 24'd1;

  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [1:0]  r_phase;
  logic [2:0]  r_bit;
  logic [1:0]  r_byte;
  logic [23:0] r_wait;
  logic [3:0]  r_index;
  logic        r_nack;
  logic        r_error;
  logic        r_busy;

  logic        w_phase_end, w_slot_end, w_sample;
  logic        w_slot, w_wait_end, w_go, w_bit;
  logic [23:0] w_wait_lim;
  logic [15:0] w_entry;
  logic [7:0]  w_byte;
  logic        w_scl_oe, w_sda_oe;

  assign w_phase_end = (r_cnt == DIV_M1);
  assign w_slot_end  = w_phase_end && (r_phase == 2'd3);
  assign w_sample    = w_phase_end && (r_phase == 2'd2);
  assign w_slot      = (r_state == S_START) || (r_state == S_BYTE) ||
                       (r_state == S_ACK)   || (r_state == S_STOP);
  assign w_wait_lim  = (r_state == S_POWERUP) ? PU_M1 : GAP_M1;
  assign w_wait_end  = (r_wait == w_wait_lim);
  assign w_go        = start &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_entry = 16'h0000;
    unique case (r_index)
      4'd0:    w_entry = 16'h4110;
      4'd1:    w_entry = 16'h9803;
      4'd2:    w_entry = 16'h9AE0;
      4'd3:    w_entry = 16'h9C30;
      4'd4:    w_entry = 16'h9D61;
      4'd5:    w_entry = 16'hA2A4;
      4'd6:    w_entry = 16'hA3A4;
      4'd7:    w_entry = 16'hE0D0;
      4'd8:    w_entry = 16'hF900;
      4'd9:    w_entry = 16'h1500;
      4'd10:   w_entry = 16'h1630;
      4'd11:   w_entry = 16'hAF16;
      default: w_entry = 16'h0000;
    endcase
  end

  always_comb begin
    w_byte = {DEV_ADDR, 1'b0};
    if (r_byte == 2'd1) w_byte = w_entry[15:8];
    if (r_byte == 2'd2) w_byte = w_entry[7:0];
  end

  assign w_bit = w_byte[3'd7 - r_bit];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_POWERUP: if (w_wait_end) w_next = S_START;
      S_IDLE:    if (start) w_next = S_START;
      S_DONE:    if (start) w_next = S_START;
      S_START:   if (w_slot_end) w_next = S_BYTE;
      S_BYTE:    if (w_slot_end && r_bit == 3'd7) w_next = S_ACK;
      S_ACK: begin
        if (w_slot_end)
          w_next = (r_nack || r_byte == 2'd2) ? S_STOP : S_BYTE;
      end
      S_STOP:    if (w_slot_end) w_next = r_nack ? S_IDLE : S_GAP;
      S_GAP: begin
        if (w_wait_end)
          w_next = (r_index == 4'd11) ? S_DONE : S_START;
      end
      default:   w_next = S_POWERUP;
    endcase
  end

  // SDA only moves on p0 entry except for the START/STOP edges
  always_comb begin
    w_scl_oe = 1'b0;
    w_sda_oe = 1'b0;
    unique case (r_state)
      S_START: w_sda_oe = r_phase[1];
      S_BYTE: begin
        w_scl_oe = ~r_phase[1];
        w_sda_oe = ~w_bit;
      end
      S_ACK:   w_scl_oe = ~r_phase[1];
      S_STOP: begin
        w_scl_oe = ~r_phase[1];
        w_sda_oe = (r_phase != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_POWERUP;
      r_cnt   <= '0;
      r_phase <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_wait  <= '0;
      r_index <= '0;
      r_nack  <= 1'b0;
      r_error <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE) && (w_next != S_DONE);
      if (w_slot) begin
        if (w_phase_end) begin
          r_cnt   <= '0;
          r_phase <= r_phase + 2'd1;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end else begin
        r_cnt   <= '0;
        r_phase <= '0;
      end
      if (r_state == S_POWERUP || r_state == S_GAP)
        r_wait <= w_wait_end ? 24'd0 : r_wait + 24'd1;
      else
        r_wait <= '0;
      if (r_state == S_START) begin
        r_bit  <= '0;
        r_byte <= '0;
      end
      if (r_state == S_BYTE && w_slot_end)
        r_bit <= r_bit + 3'd1;
      if (r_state == S_ACK && w_sample)
        r_nack <= sda_in;
      if (r_state == S_ACK && w_slot_end)
        r_byte <= r_byte + 2'd1;
      if (w_go) begin
        r_index <= '0;
        r_error <= 1'b0;
      end
      if (r_state == S_GAP && w_wait_end && r_index != 4'd11)
        r_index <= r_index + 4'd1;
      if (r_state == S_STOP && w_slot_end && r_nack)
        r_error <= 1'b1;
    end
  end

  assign scl_oe = w_scl_oe;
  assign sda_oe = w_sda_oe;
  assign busy   = r_busy;
  assign done   = (r_state == S_DONE);
  assign error  = r_error;
  assign index  = r_index;

endmodule
